// File: rtl/bot_event_latch_if.sv
// CPU-facing control/status bundle of the event latch: masks, acks and
// clears in, pending/overflow/interrupt/counter status out.
interface bot_event_latch_if #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 8
);
  localparam int ID_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [N_CH-1:0]       i_en;
  logic [N_CH-1:0]       i_ack;
  logic                  i_ovf_clr;
  logic [N_CH-1:0]       i_cnt_clr;
  logic [N_CH-1:0]       o_pending;
  logic [N_CH-1:0]       o_overflow;
  logic                  o_irq;
  logic [ID_W-1:0]       o_irq_id;
  logic [N_CH*CNT_W-1:0] o_evt_cnt;

  // CPU / interrupt-controller side
  modport master (
    output i_en, i_ack, i_ovf_clr, i_cnt_clr,
    input  o_pending, o_overflow, o_irq, o_irq_id, o_evt_cnt
  );

  // Event latch side
  modport slave (
    input  i_en, i_ack, i_ovf_clr, i_cnt_clr,
    output o_pending, o_overflow, o_irq, o_irq_id, o_evt_cnt
  );
endinterface

// File: rtl/bot_event_latch.sv
// N-channel event capture: synchronise async event lines, detect edge or
// level, latch into pending bits until acked, count events (saturating),
// flag overruns and present a masked lowest-index-first interrupt.
module bot_event_latch #(
  parameter int              N_CH        = 4,
  parameter int              SYNC_STAGES = 2,
  parameter logic [N_CH-1:0] LEVEL_MODE  = '0,
  parameter int              CNT_W       = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [N_CH-1:0]   i_evt,
  bot_event_latch_if.slave  bus
);
  localparam int ID_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [N_CH-1:0] w_sync_out;   // last synchroniser stage per channel
  logic [N_CH-1:0] r_hist;       // synchronised value one cycle ago
  logic [N_CH-1:0] w_evt;        // detected event pulse per channel
  logic [N_CH-1:0] r_pending;
  logic [N_CH-1:0] r_overflow;
  logic [N_CH-1:0] w_irq_vec;
  logic [ID_W-1:0] w_irq_id;

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      logic [SYNC_STAGES-1:0] r_sync;
      logic [CNT_W-1:0]       r_cnt;

      // Plain flop chain into clk; no logic between stages
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_sync <= '0;
        else       r_sync <= {r_sync[SYNC_STAGES-2:0], i_evt[gi]};
      end

      assign w_sync_out[gi] = r_sync[SYNC_STAGES-1];

      // Level channels fire every cycle the line is high, edge channels once per rise
      assign w_evt[gi] = LEVEL_MODE[gi] ? w_sync_out[gi]
                                        : (w_sync_out[gi] & ~r_hist[gi]);

      // Saturating event counter; a clear coinciding with an event leaves one count
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          r_cnt <= '0;
        end else if (bus.i_cnt_clr[gi]) begin
          r_cnt <= CNT_W'(w_evt[gi]);
        end else if (w_evt[gi] && (r_cnt != {CNT_W{1'b1}})) begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end

      assign bus.o_evt_cnt[gi*CNT_W +: CNT_W] = r_cnt;
    end
  endgenerate

  // Edge history; resets to 0 so a line held high across reset reads as an edge
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_hist <= '0;
    else       r_hist <= w_sync_out;
  end

  // Pending: a new event beats a simultaneous ack so nothing is lost
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_pending <= '0;
    else       r_pending <= (r_pending & ~bus.i_ack) | w_evt;
  end

  // Sticky overrun flag; a fresh overrun beats the global clear
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_overflow <= '0;
    else       r_overflow <= (bus.i_ovf_clr ? '0 : r_overflow)
                              | (w_evt & r_pending & ~bus.i_ack);
  end

  assign w_irq_vec = r_pending & bus.i_en;

  // Priority encode: scan high to low so the lowest set index is written last
  always_comb begin
    w_irq_id = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (w_irq_vec[k]) w_irq_id = ID_W'(k);
    end
  end

  assign bus.o_pending  = r_pending;
  assign bus.o_overflow = r_overflow;
  assign bus.o_irq      = |w_irq_vec;
  assign bus.o_irq_id   = w_irq_id;

endmodule

// File: tb/tb_bot_event_latch.sv
// Directed, table-driven bench for bot_event_latch (4 channels, 2 sync
// stages, channel 3 in level mode, 4-bit counters).
module tb_bot_event_latch;
  logic       clk = 1'b0;
  logic       rstn;
  logic [3:0] evt;
  int         n_err = 0;
  int         n_checks = 0;

  always #5 clk = ~clk;

  bot_event_latch_if #(.N_CH(4), .CNT_W(4)) bus_if ();

  bot_event_latch #(
    .N_CH(4), .SYNC_STAGES(2), .LEVEL_MODE(4'b1000), .CNT_W(4)
  ) dut (
    .clk   (clk),
    .rstn  (rstn),
    .i_evt (evt),
    .bus   (bus_if.slave)
  );

  typedef struct {
    logic [3:0]  evt;
    logic [3:0]  en;
    logic [3:0]  ack;
    logic        ovf_clr;
    logic [3:0]  cnt_clr;
    logic [3:0]  pend;
    logic [3:0]  ovf;
    logic        irq;
    logic [1:0]  id;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic [3:0] e, logic [3:0] en, logic [3:0] ack,
                              logic oc, logic [3:0] cc, logic [3:0] p,
                              logic [3:0] o, logic irq, logic [1:0] id,
                              logic [15:0] cnt);
    vec_t v;
    v.evt = e; v.en = en; v.ack = ack; v.ovf_clr = oc; v.cnt_clr = cc;
    v.pend = p; v.ovf = o; v.irq = irq; v.id = id; v.cnt = cnt;
    vecs.push_back(v);
  endfunction

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(string tag, logic [3:0] p, logic [3:0] o, logic irq,
                         logic [1:0] id, logic [15:0] cnt);
    chk({tag, ".pending"},  16'(bus_if.o_pending),  16'(p));
    chk({tag, ".overflow"}, 16'(bus_if.o_overflow), 16'(o));
    chk({tag, ".irq"},      16'(bus_if.o_irq),      16'(irq));
    chk({tag, ".irq_id"},   16'(bus_if.o_irq_id),   16'(id));
    chk({tag, ".cnt"},      bus_if.o_evt_cnt,       cnt);
  endtask

  initial begin
    // step: evt en ack ovf_clr cnt_clr | pending overflow irq id cnt{3,2,1,0}
    // Reset/latency on ch2
    add(4'h4, 4'hF, 4'h0, 0, 4'h0,  4'h0, 4'h0, 0, 2'd0, 16'h0000); // 0
    add(4'h4, 4'hF, 4'h0, 0, 4'h0,  4'h0, 4'h0, 0, 2'd0, 16'h0000); // 1
    add(4'h4, 4'hF, 4'h0, 0, 4'h0,  4'h4, 4'h0, 1, 2'd2, 16'h0100); // 2
    add(4'h0, 4'hF, 4'h0, 0, 4'h0,  4'h4, 4'h0, 1, 2'd2, 16'h0100); // 3
    add(4'h0, 4'hF, 4'h0, 0, 4'h0,  4'h4, 4'h0, 1, 2'd2, 16'h0100); // 4
    add(4'h0, 4'hF, 4'h0, 0, 4'h0,  4'h4, 4'h0, 1, 2'd2, 16'h0100); // 5
    add(4'h0, 4'hF, 4'h4, 0, 4'h0,  4'h0, 4'h0, 0, 2'd0, 16'h0100); // 6
    // Ack coinciding with a new event on ch1
    add(4'h2, 4'hF, 4'h0, 0, 4'h0,  4'h0, 4'h0, 0, 2'd0, 16'h0100); // 7
    add(4'h2, 4'hF, 4'h0, 0, 4'h0,  4'h0, 4'h0, 0, 2'd0, 16'h0100); // 8
    add(4'h0, 4'hF, 4'h0, 0, 4'h0,  4'h2, 4'h0, 1, 2'd1, 16'h0110); // 9
    add(4'h0, 4'hF, 4'h0, 0, 4'h0,  4'h2, 4'h0, 1, 2'd1, 16'h0110); // 10
    add(4'h2, 4'hF, 4'h0, 0, 4'h0,  4'h2, 4'h0, 1, 2'd1, 16'h0110); // 11
    add(4'h2, 4'hF, 4'h0, 0, 4'h0,  4'h2, 4'h0, 1, 2'd1, 16'h0110); // 12
    add(4'h0, 4'hF, 4'h2, 0, 4'h0,  4'h2, 4'h0, 1, 2'd1, 16'h0120); // 13
    add(4'h0, 4'hF, 4'h2, 0, 4'h0,  4'h0, 4'h0, 0, 2'd0, 16'h0120); // 14
    // Overflow on ch0, clear, and set-beats-clear
    add(4'h1, 4'hF, 4'h0, 0, 4'h0,  4'h0, 4'h0, 0, 2'd0, 16'h0120); // 15
    add(4'h1, 4'hF, 4'h0, 0, 4'h0,  4'h0, 4'h0, 0, 2'd0, 16'h0120); // 16
    add(4'h0, 4'hF, 4'h0, 0, 4'h0,  4'h1, 4'h0, 1, 2'd0, 16'h0121); // 17
    add(4'h0, 4'hF, 4'h0, 0, 4'h0,  4'h1, 4'h0, 1, 2'd0, 16'h0121); // 18
    add(4'h1, 4'hF, 4'h0, 0, 4'h0,  4'h1, 4'h0, 1, 2'd0, 16'h0121); // 19
    add(4'h1, 4'hF, 4'h0, 0, 4'h0,  4'h1, 4'h0, 1, 2'd0, 16'h0121); // 20
    add(4'h0, 4'hF, 4'h0, 0, 4'h0,  4'h1, 4'h1, 1, 2'd0, 16'h0122); // 21
    add(4'h0, 4'hF, 4'h0, 1, 4'h0,  4'h1, 4'h0, 1, 2'd0, 16'h0122); // 22
    add(4'h1, 4'hF, 4'h0, 0, 4'h0,  4'h1, 4'h0, 1, 2'd0, 16'h0122); // 23
    add(4'h1, 4'hF, 4'h0, 0, 4'h0,  4'h1, 4'h0, 1, 2'd0, 16'h0122); // 24
    add(4'h0, 4'hF, 4'h0, 1, 4'h0,  4'h1, 4'h1, 1, 2'd0, 16'h0123); // 25
    add(4'h0, 4'hF, 4'h0, 1, 4'h0,  4'h1, 4'h0, 1, 2'd0, 16'h0123); // 26
    add(4'h0, 4'hF, 4'h1, 0, 4'h0,  4'h0, 4'h0, 0, 2'd0, 16'h0123); // 27
    // Priority and masking with ch1 and ch3 (level) pending
    add(4'hA, 4'hF, 4'h0, 0, 4'h0,  4'h0, 4'h0, 0, 2'd0, 16'h0123); // 28
    add(4'hA, 4'hF, 4'h0, 0, 4'h0,  4'h0, 4'h0, 0, 2'd0, 16'h0123); // 29
    add(4'h0, 4'h8, 4'h0, 0, 4'h0,  4'hA, 4'h0, 1, 2'd3, 16'h1133); // 30
    add(4'h0, 4'h8, 4'h0, 0, 4'h0,  4'hA, 4'h8, 1, 2'd3, 16'h2133); // 31
    add(4'h0, 4'hF, 4'h0, 0, 4'h0,  4'hA, 4'h8, 1, 2'd1, 16'h2133); // 32
    add(4'h0, 4'hF, 4'h2, 0, 4'h0,  4'h8, 4'h8, 1, 2'd3, 16'h2133); // 33
    add(4'h0, 4'hF, 4'h8, 1, 4'h0,  4'h0, 4'h0, 0, 2'd0, 16'h2133); // 34
    // Level mode ch3: held high 10 cycles, acked while the pin is high
    add(4'h8, 4'hF, 4'h8, 0, 4'h8,  4'h0, 4'h0, 0, 2'd0, 16'h0133); // 35
    add(4'h8, 4'hF, 4'h8, 0, 4'h0,  4'h0, 4'h0, 0, 2'd0, 16'h0133); // 36
    add(4'h8, 4'hF, 4'h8, 0, 4'h0,  4'h8, 4'h0, 1, 2'd3, 16'h1133); // 37
    add(4'h8, 4'hF, 4'h8, 0, 4'h0,  4'h8, 4'h0, 1, 2'd3, 16'h2133); // 38
    for (int k = 3; k <= 8; k++)                                     // 39..44
      add(4'h8, 4'hF, 4'h8, 0, 4'h0, 4'h8, 4'h0, 1, 2'd3, {4'(k), 12'h133});
    add(4'h0, 4'hF, 4'h0, 0, 4'h0,  4'h8, 4'h8, 1, 2'd3, 16'h9133); // 45
    add(4'h0, 4'hF, 4'h0, 0, 4'h0,  4'h8, 4'h8, 1, 2'd3, 16'hA133); // 46
    add(4'h0, 4'hF, 4'h8, 0, 4'h0,  4'h0, 4'h8, 0, 2'd0, 16'hA133); // 47
    // Mask does not gate capture; re-enable raises irq in the same cycle
    add(4'h4, 4'h0, 4'h0, 1, 4'h0,  4'h0, 4'h0, 0, 2'd0, 16'hA133); // 48
    add(4'h4, 4'h0, 4'h0, 0, 4'h0,  4'h0, 4'h0, 0, 2'd0, 16'hA133); // 49
    add(4'h0, 4'h0, 4'h0, 0, 4'h0,  4'h4, 4'h0, 0, 2'd0, 16'hA233); // 50
    add(4'h0, 4'h4, 4'h0, 0, 4'h0,  4'h4, 4'h0, 1, 2'd2, 16'hA233); // 51
    add(4'h0, 4'hF, 4'h4, 0, 4'h0,  4'h0, 4'h0, 0, 2'd0, 16'hA233); // 52

    // Reset
    rstn = 1'b0;
    evt = '0;
    bus_if.i_en = '0; bus_if.i_ack = '0; bus_if.i_ovf_clr = 1'b0; bus_if.i_cnt_clr = '0;
    repeat (3) tick();
    chk_all("reset", 4'h0, 4'h0, 1'b0, 2'd0, 16'h0000);
    rstn = 1'b1;

    // Table
    foreach (vecs[i]) begin
      evt = vecs[i].evt;
      bus_if.i_en = vecs[i].en;
      bus_if.i_ack = vecs[i].ack;
      bus_if.i_ovf_clr = vecs[i].ovf_clr;
      bus_if.i_cnt_clr = vecs[i].cnt_clr;
      tick();
      chk_all($sformatf("v%0d", i), vecs[i].pend, vecs[i].ovf, vecs[i].irq,
              vecs[i].id, vecs[i].cnt);
    end
    evt = '0; bus_if.i_en = 4'hF; bus_if.i_ack = '0;
    bus_if.i_ovf_clr = 1'b0; bus_if.i_cnt_clr = '0;

    // Saturation on ch0
    bus_if.i_cnt_clr = 4'h1;
    tick();
    bus_if.i_cnt_clr = 4'h0;
    chk("sat.clr", bus_if.o_evt_cnt, 16'hA230);
    for (int i = 1; i <= 20; i++) begin
      evt = 4'h1; tick(); tick();
      evt = 4'h0; tick(); tick();
      if (i == 14) chk("sat.14", bus_if.o_evt_cnt, 16'hA23E);
      if (i == 15) chk("sat.15", bus_if.o_evt_cnt, 16'hA23F);
    end
    chk("sat.20", bus_if.o_evt_cnt, 16'hA23F);
    chk("sat.ovf", 16'(bus_if.o_overflow), 16'h0001);

    // Counter clear coinciding with an event leaves a count of one
    evt = 4'h1; tick(); tick();
    evt = 4'h0; bus_if.i_cnt_clr = 4'h1; tick();
    bus_if.i_cnt_clr = 4'h0;
    chk("clr_evt.cnt", bus_if.o_evt_cnt, 16'hA231);
    tick();
    chk("clr_evt.hold", bus_if.o_evt_cnt, 16'hA231);

    // Asynchronous reset mid-operation, line held high across release
    evt = 4'h2; tick(); tick(); tick();
    chk("pre_rst.pending", 16'(bus_if.o_pending), 16'h0003);
    #2 rstn = 1'b0;
    #1 chk_all("async_rst", 4'h0, 4'h0, 1'b0, 2'd0, 16'h0000);
    tick();
    rstn = 1'b1;
    tick();
    chk("rel.e1.pending", 16'(bus_if.o_pending), 16'h0000);
    tick();
    chk("rel.e2.pending", 16'(bus_if.o_pending), 16'h0000);
    tick();
    chk_all("rel.e3", 4'h2, 4'h0, 1'b1, 2'd1, 16'h0010);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
